// File: rtl/seq_array_multiplier_if.sv
// Start/busy/done handshake and operand/product bus for the sequential array multiplier.
interface seq_array_multiplier_if #(
  parameter int SIZE = 4
);
  logic              start;
  logic [SIZE-1:0]   a;
  logic [SIZE-1:0]   b;
  logic              busy;
  logic              done;
  logic [2*SIZE-1:0] product;

  modport master (output start, a, b, input busy, done, product);
  modport slave  (input start, a, b, output busy, done, product);
endinterface

// File: rtl/seq_array_multiplier.sv
// Sequential unsigned SIZE x SIZE multiplier: one row of EMUL full-adder cells
// is reused to fold in one partial-product row per clock.
module seq_array_multiplier #(
  parameter int SIZE = 4
) (
  input  logic                 Clock,
  input  logic                 Reset,
  seq_array_multiplier_if.slave bus
);

  localparam int ROW_W = $clog2(SIZE);
  localparam int PW    = 2 * SIZE;
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(SIZE - 1);
  localparam logic [PW-1:0]    ROW_MASK = {{(PW-SIZE-1){1'b0}}, {(SIZE+1){1'b1}}};

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state_p0, state_nxt;
  logic [SIZE-1:0]   a_p0, b_p0;
  logic [ROW_W-1:0]  row_p0;
  logic [PW-1:0]     acc_p0;
  logic [PW-1:0]     product_p1;

  logic              accept, step, last;
  logic [SIZE-1:0]   window, pp;
  logic [SIZE:0]     row_sum;
  logic [PW-1:0]     acc_nxt;

  // One row of SIZE EMUL cells with rippling carry; bit SIZE is the carry-out.
  function automatic logic [SIZE:0] emul_row(input logic [SIZE-1:0] x,
                                             input logic [SIZE-1:0] y);
    logic [SIZE:0] r;
    logic          c;
    c = 1'b0;
    for (int i = 0; i < SIZE; i++) begin
      r[i] = x[i] ^ y[i] ^ c;
      c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
    end
    r[SIZE] = c;
    return r;
  endfunction

  always_comb begin
    state_nxt = state_p0;
    accept    = 1'b0;
    step      = 1'b0;
    last      = 1'b0;
    case (state_p0)
      IDLE: begin
        if (bus.start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (row_p0 == LAST_ROW) begin
          last      = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (bus.start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Accumulator bits above row+SIZE are still zero, so the carry-out lands in an empty bit.
  always_comb begin
    window  = SIZE'(acc_p0 >> row_p0);
    pp      = a_p0 & {SIZE{b_p0[row_p0]}};
    row_sum = emul_row(window, pp);
    acc_nxt = (acc_p0 & ~(ROW_MASK << row_p0)) | (PW'(row_sum) << row_p0);
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_p0 <= IDLE;
    end else begin
      state_p0 <= state_nxt;
    end
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      a_p0       <= '0;
      b_p0       <= '0;
      row_p0     <= '0;
      acc_p0     <= '0;
      product_p1 <= '0;
    end else begin
      if (accept) begin
        a_p0   <= bus.a;
        b_p0   <= bus.b;
        acc_p0 <= '0;
        row_p0 <= '0;
      end else if (step) begin
        acc_p0 <= acc_nxt;
        if (!last) row_p0 <= row_p0 + 1'b1;
      end
      // stage boundary: final row result is published as the product
      if (last) product_p1 <= acc_nxt;
    end
  end

  assign bus.busy    = (state_p0 == RUN);
  assign bus.done    = (state_p0 == DONE);
  assign bus.product = product_p1;

endmodule

// File: tb/tb_seq_array_multiplier.sv
// Directed and randomized bench for seq_array_multiplier against a plain a*b model.
module tb_seq_array_multiplier;

  localparam int SIZE = 4;

  logic Clock = 1'b0;
  logic Reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  seq_array_multiplier_if #(.SIZE(4)) bus4 ();
  seq_array_multiplier_if #(.SIZE(8)) bus8 ();

  seq_array_multiplier #(.SIZE(4)) dut4 (.Clock(Clock), .Reset(Reset), .bus(bus4.slave));
  seq_array_multiplier #(.SIZE(8)) dut8 (.Clock(Clock), .Reset(Reset), .bus(bus8.slave));

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // Launch one multiply on the 4-bit unit, scramble operands during RUN, and check
  // latency, busy length, product and the one-cycle done pulse.
  task automatic run_mul(input int a, input int b, input string tag);
    int exp, cyc, busy_cnt;
    exp          = a * b;
    bus4.start   = 1'b1;
    bus4.a       = 4'(a);
    bus4.b       = 4'(b);
    tick();
    bus4.start   = 1'b0;
    cyc          = 1;
    busy_cnt     = 0;
    while (!bus4.done && cyc < 4 * SIZE) begin
      if (bus4.busy) busy_cnt++;
      bus4.a = 4'($urandom_range(0, 15));
      bus4.b = 4'($urandom_range(0, 15));
      tick();
      cyc++;
    end
    check({tag, " done"}, 32'(bus4.done), 1);
    check({tag, " edges"}, cyc, SIZE + 1);
    check({tag, " busy_cycles"}, busy_cnt, SIZE);
    check({tag, " product"}, 32'(bus4.product), exp);
    tick();
    check({tag, " done_pulse"}, 32'(bus4.done), 0);
    check({tag, " hold"}, 32'(bus4.product), exp);
  endtask

  initial begin
    int cyc, dones, prod_seen, ra, rb;
    Reset      = 1'b0;
    bus4.start = 1'b1;
    bus4.a     = 4'd3;
    bus4.b     = 4'd3;
    bus8.start = 1'b0;
    bus8.a     = '0;
    bus8.b     = '0;
    tick();
    tick();
    check("rst busy", 32'(bus4.busy), 0);
    check("rst done", 32'(bus4.done), 0);
    check("rst product", 32'(bus4.product), 0);
    check("rst8 product", 32'(bus8.product), 0);
    bus4.start = 1'b0;
    Reset      = 1'b1;
    tick();
    check("idle busy", 32'(bus4.busy), 0);

    run_mul(13, 11, "13x11");
    run_mul(15, 15, "15x15");
    run_mul(0, 9, "0x9");

    // Start in RUN is ignored.
    bus4.start = 1'b1; bus4.a = 4'd7; bus4.b = 4'd6;
    tick();
    bus4.start = 1'b0;
    tick();
    bus4.start = 1'b1; bus4.a = 4'd3;
    tick();
    bus4.start = 1'b0;
    dones = 0; prod_seen = 0;
    for (int i = 0; i < 3 * SIZE; i++) begin
      if (bus4.done) begin dones++; prod_seen = 32'(bus4.product); end
      tick();
    end
    check("ignore done_count", dones, 1);
    check("ignore product", prod_seen, 42);

    // Back-to-back with start held through DONE.
    bus4.start = 1'b1; bus4.a = 4'd9; bus4.b = 4'd9;
    tick();
    bus4.a = 4'd5; bus4.b = 4'd5;
    cyc = 1;
    while (!bus4.done && cyc < 4 * SIZE) begin tick(); cyc++; end
    check("b2b first", 32'(bus4.product), 81);
    check("b2b first_edges", cyc, SIZE + 1);
    tick();
    check("b2b rerun busy", 32'(bus4.busy), 1);
    check("b2b rerun done", 32'(bus4.done), 0);
    bus4.start = 1'b0;
    cyc = 1;
    while (!bus4.done && cyc < 4 * SIZE) begin tick(); cyc++; end
    check("b2b second", 32'(bus4.product), 25);
    check("b2b period", cyc, SIZE + 1);
    tick();

    // Reset mid-RUN aborts.
    bus4.start = 1'b1; bus4.a = 4'd12; bus4.b = 4'd10;
    tick();
    bus4.start = 1'b0;
    tick();
    Reset = 1'b0;
    tick();
    check("abort busy", 32'(bus4.busy), 0);
    check("abort product", 32'(bus4.product), 0);
    check("abort done", 32'(bus4.done), 0);
    Reset = 1'b1;
    dones = 0;
    for (int i = 0; i < SIZE + 2; i++) begin
      if (bus4.done) dones++;
      tick();
    end
    check("abort no_done", dones, 0);
    run_mul(12, 10, "post_abort");

    // Randomized operands.
    for (int i = 0; i < 24; i++) begin
      ra = $urandom_range(0, 15);
      rb = $urandom_range(0, 15);
      run_mul(ra, rb, "rand");
    end

    // Exhaustive 4-bit sweep.
    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 16; y++)
        run_mul(x, y, "sweep");

    // 8-bit instance: maximum operands and a few random ones.
    for (int i = 0; i < 4; i++) begin
      ra = (i == 0) ? 255 : $urandom_range(0, 255);
      rb = (i == 0) ? 255 : $urandom_range(0, 255);
      bus8.start = 1'b1; bus8.a = 8'(ra); bus8.b = 8'(rb);
      tick();
      bus8.start = 1'b0;
      cyc = 1;
      while (!bus8.done && cyc < 40) begin tick(); cyc++; end
      check("size8 edges", cyc, 9);
      check("size8 product", 32'(bus8.product), ra * rb);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
